flash_spi_reader: RTL

Byte-granular SPI NOR flash read engine that sits directly upstream of `flash_fetcher` and supplies the byte it latches into `flash_data`. It accepts a 24-bit byte address on a single-cycle request, issues a standard READ (0x03) transaction in SPI mode 0, and returns one byte with a one-cycle valid strobe. An optional streaming mode keeps chip-select asserted so that forward-sequential reads skip the command and address phases.

---
 rtl/flash_spi_reader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/flash_spi_reader.sv
// Byte-granular SPI NOR flash READ (0x03) engine, SPI mode 0, one byte per request.
// Define FLASH_STREAM_EN to keep CS asserted between reads so sequential addresses skip CMD/ADDR.
module flash_spi_reader #(
    parameter int          CLK_DIV  = 2,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [23:0] rd_addr,
    output logic        rd_busy,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_GAP,
        S_HOLD
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic               sck_q;
    logic               cs_n_q;
    logic               mosi_q;
    logic               busy_q;
    logic               valid_q;
    logic [7:0]         data_q;
    logic [7:0]         rx_q;
    logic [31:0]        shift_q;
    logic [4:0]         bit_q;
    logic [GAP_W-1:0]   gap_q;
`ifdef FLASH_STREAM_EN
    logic [23:0]        addr_q;
    logic               restart_q;
    logic               seq_hit;
`endif

    logic phase_end;
    logic bit_end;

    // A bit ends on the last cycle of its high phase; MISO is sampled there too.
    assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_end   = phase_end && sck_q;

`ifdef FLASH_STREAM_EN
    assign seq_hit = (rd_addr == addr_q + 24'd1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            rx_q      <= 8'h00;
            shift_q   <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
`ifdef FLASH_STREAM_EN
            addr_q    <= '0;
            restart_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rd_req) begin
`ifdef FLASH_STREAM_EN
                        addr_q  <= rd_addr;
`endif
                        shift_q <= {READ_CMD, rd_addr};
                        mosi_q  <= READ_CMD[7];
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= '0;
                        sck_q   <= 1'b0;
                        bit_q   <= '0;
                        state_q <= S_CMD;
                    end
                end

                S_CMD, S_ADDR, S_DATA: begin
                    if (phase_end) begin
                        div_q <= '0;
                        sck_q <= ~sck_q;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                    if (bit_end) begin
                        bit_q   <= bit_q + 5'd1;
                        shift_q <= shift_q << 1;
                        mosi_q  <= shift_q[30];
                        if (state_q == S_CMD && bit_q == 5'd7) begin
                            bit_q   <= '0;
                            state_q <= S_ADDR;
                        end
                        if (state_q == S_ADDR && bit_q == 5'd23) begin
                            bit_q   <= '0;
                            mosi_q  <= 1'b0;
                            state_q <= S_DATA;
                        end
                        if (state_q == S_DATA) begin
                            mosi_q <= 1'b0;
                            rx_q   <= {rx_q[6:0], spi_miso};
                            if (bit_q == 5'd7) begin
                                data_q  <= {rx_q[6:0], spi_miso};
                                valid_q <= 1'b1;
                                bit_q   <= '0;
`ifdef FLASH_STREAM_EN
                                busy_q  <= 1'b0;
                                state_q <= S_HOLD;
`else
                                // The valid cycle opens the CS-high window, which then runs 2*CLK_DIV more cycles.
                                cs_n_q  <= 1'b1;
                                gap_q   <= GAP_W'(2 * CLK_DIV);
                                state_q <= S_GAP;
`endif
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (gap_q == '0) begin
`ifdef FLASH_STREAM_EN
                        if (restart_q) begin
                            restart_q <= 1'b0;
                            mosi_q    <= shift_q[31];
                            cs_n_q    <= 1'b0;
                            div_q     <= '0;
                            sck_q     <= 1'b0;
                            bit_q     <= '0;
                            state_q   <= S_CMD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
`else
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end

`ifdef FLASH_STREAM_EN
                S_HOLD: begin
                    if (rd_req) begin
                        addr_q <= rd_addr;
                        busy_q <= 1'b1;
                        div_q  <= '0;
                        sck_q  <= 1'b0;
                        bit_q  <= '0;
                        if (seq_hit) begin
                            mosi_q  <= 1'b0;
                            state_q <= S_DATA;
                        end else begin
                            // Non-sequential: drop CS for 2*CLK_DIV cycles, then re-command the flash.
                            shift_q   <= {READ_CMD, rd_addr};
                            cs_n_q    <= 1'b1;
                            restart_q <= 1'b1;
                            gap_q     <= GAP_W'(2 * CLK_DIV - 1);
                            state_q   <= S_GAP;
                        end
                    end
                end
`endif

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_busy  = busy_q;
    assign rd_valid = valid_q;
    assign rd_data  = data_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;

endmodule
